// File: rtl/dmem_arb_pkg.sv
// Shared types for the DataMem arbiter: access size codes, FSM states, requester indices.
// No logic; imported by dmem_rr_arb and dmem_arbiter.
package dmem_arb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } dmem_arb_state_t;

    localparam int unsigned REQ_CORE = 0;
    localparam int unsigned REQ_LDR  = 1;

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-way round-robin arbiter producing a one-hot grant.
// Latency: grant is combinational from req; priority state updates on the granting edge.
// Backpressure: no grant while en is low; an ungranted requester simply keeps req high.
module dmem_rr_arb
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // 1 = loader won most recently, so the core wins the next tie
    logic rr_last;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last <= 1'b1;
        end else if (|gnt) begin
            rr_last <= gnt[REQ_LDR];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares DataMem between core and loader; optional zero-fill sweep via DMEM_CLEAR_ON_RESET_EN.
// Latency: grant same cycle as req, write commits at that edge, read data one cycle after grant.
// Backpressure: loser (and everyone during the sweep) holds req until its gnt; one access per cycle.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_DEPTH = 16,
    parameter int ADDR_W    = $clog2(MEM_DEPTH),
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    input  logic [1:0]        c_strb,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,

    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic [1:0]        l_strb,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,

    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] wr_addr0,
    output logic [DATA_W-1:0] wr_din0,
    output logic              we0,
    output logic [1:0]        wr_strb,
    input  logic [DATA_W-1:0] rd_dout0,
    output logic              init_done
);

    logic [1:0]        gnt;
    logic              sweep;
    logic [ADDR_W-1:0] sweep_addr;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic [1:0]        win_strb;
    logic              rd_fire;
    logic              rd_pend;
    logic              rd_owner;
    logic [ADDR_W-1:0] rd_addr_q;

    dmem_rr_arb u_rr_arb (
        .clk (clk),
        .rst (rst),
        .en  (init_done),
        .req ({l_req, c_req}),
        .gnt (gnt)
    );

    assign c_gnt = gnt[REQ_CORE];
    assign l_gnt = gnt[REQ_LDR];

    assign win_we    = gnt[REQ_LDR] ? l_we    : c_we;
    assign win_addr  = gnt[REQ_LDR] ? l_addr  : c_addr;
    assign win_wdata = gnt[REQ_LDR] ? l_wdata : c_wdata;
    assign win_strb  = gnt[REQ_LDR] ? l_strb  : c_strb;
    assign rd_fire   = (|gnt) && !win_we;

`ifdef DMEM_CLEAR_ON_RESET_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    dmem_arb_state_t   state;
    logic [ADDR_W-1:0] init_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else if (state == INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == LAST_ADDR) begin
                state     <= RUN;
                init_done <= 1'b1;
            end
        end
    end

    // Qualified with rst so the write port is quiet while reset is held
    assign sweep      = rst && (state == INIT);
    assign sweep_addr = init_cnt;
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
        end
    end

    assign sweep      = 1'b0;
    assign sweep_addr = '0;
`endif

    always_comb begin
        we0      = 1'b0;
        wr_addr0 = '0;
        wr_din0  = '0;
        wr_strb  = '0;
        if (sweep) begin
            we0      = 1'b1;
            wr_addr0 = sweep_addr;
            wr_strb  = SZ_WORD;
        end else if ((|gnt) && win_we) begin
            we0      = 1'b1;
            wr_addr0 = win_addr;
            wr_din0  = win_wdata;
            wr_strb  = win_strb;
        end
    end

    assign rd_addr0 = rd_fire ? win_addr : rd_addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend   <= 1'b0;
            rd_owner  <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            rd_pend <= rd_fire;
            if (rd_fire) begin
                rd_owner  <= gnt[REQ_LDR];
                rd_addr_q <= win_addr;
            end
        end
    end

    assign c_rvalid = rd_pend && !rd_owner;
    assign l_rvalid = rd_pend && rd_owner;
    assign c_rdata  = rd_dout0;
    assign l_rdata  = rd_dout0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized + directed bench for dmem_arbiter with a behavioural DataMem stand-in and a spec-level model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 32;
`ifdef DMEM_CLEAR_ON_RESET_EN
    localparam bit CLEAR    = 1'b1;
    localparam int INIT_CYC = 16;
`else
    localparam bit CLEAR    = 1'b0;
    localparam int INIT_CYC = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          c_req, c_we, c_gnt, c_rvalid;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata, c_rdata;
    logic [1:0]    c_strb;
    logic          l_req, l_we, l_gnt, l_rvalid;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata, l_rdata;
    logic [1:0]    l_strb;
    logic [AW-1:0] rd_addr0, wr_addr0;
    logic [DW-1:0] wr_din0, rd_dout0;
    logic          we0, init_done;
    logic [1:0]    wr_strb;
    logic          preload;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_strb(c_strb),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_strb(l_strb),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .rd_addr0(rd_addr0), .wr_addr0(wr_addr0), .wr_din0(wr_din0), .we0(we0),
        .wr_strb(wr_strb), .rd_dout0(rd_dout0), .init_done(init_done)
    );

    // DataMem stand-in: registered read, write on the edge; stores whole words, size code is checked at the port
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hDEADBEEF;
        end else if (we0) begin
            mem[wr_addr0] <= wr_din0;
        end
        rd_dout0 <= mem[rd_addr0];
    end

    typedef struct packed {
        logic          vld;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [1:0]    strb;
    } txn_t;

    txn_t          c_t, l_t;
    logic [DW-1:0] ref_mem [DEPTH];
    bit            last_core;
    bit            rv_c, rv_l;
    logic [DW-1:0] rv_dat;
    int            k;
    int            n_tests;
    int            n_fail;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, k);
        end
    endtask

    task automatic drive();
        c_req = c_t.vld; c_we = c_t.we; c_addr = c_t.addr; c_wdata = c_t.wdata; c_strb = c_t.strb;
        l_req = l_t.vld; l_we = l_t.we; l_addr = l_t.addr; l_wdata = l_t.wdata; l_strb = l_t.strb;
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.vld   = 1'b1;
        t.we    = 1'($urandom_range(0, 1));
        t.addr  = AW'($urandom_range(0, DEPTH - 1));
        t.wdata = $urandom;
        t.strb  = 2'($urandom_range(0, 2));
        return t;
    endfunction

    // One clock cycle: drive pending requests, check at negedge against the model, advance past the edge
    task automatic cycle(output bit cg, output bit lg);
        bit   acc, ec, el, sweep_exp;
        txn_t w;
        drive();
        @(negedge clk);
        acc       = (k >= INIT_CYC);
        sweep_exp = CLEAR && !acc;
        chk("init_done", init_done, acc);
        ec = 1'b0;
        el = 1'b0;
        if (acc) begin
            if (c_t.vld && l_t.vld) begin
                ec = !last_core;
                el = last_core;
            end else begin
                ec = c_t.vld;
                el = l_t.vld;
            end
        end
        chk("c_gnt", c_gnt, ec);
        chk("l_gnt", l_gnt, el);
        chk("c_rvalid", c_rvalid, rv_c);
        chk("l_rvalid", l_rvalid, rv_l);
        if (rv_c) chk("c_rdata", c_rdata, rv_dat);
        if (rv_l) chk("l_rdata", l_rdata, rv_dat);
        w    = el ? l_t : c_t;
        rv_c = 1'b0;
        rv_l = 1'b0;
        if (sweep_exp) begin
            chk("sweep_we0", we0, 1);
            chk("sweep_addr", wr_addr0, 32'(k));
            chk("sweep_din", wr_din0, 0);
            chk("sweep_strb", wr_strb, SZ_WORD);
        end else if ((ec || el) && w.we) begin
            chk("wr_we0", we0, 1);
            chk("wr_addr0", wr_addr0, w.addr);
            chk("wr_din0", wr_din0, w.wdata);
            chk("wr_strb", wr_strb, w.strb);
            ref_mem[w.addr] = w.wdata;
        end else if (ec || el) begin
            chk("rd_we0", we0, 0);
            chk("rd_addr0", rd_addr0, w.addr);
            rv_c   = ec;
            rv_l   = el;
            rv_dat = ref_mem[w.addr];
        end else begin
            chk("idle_we0", we0, 0);
            chk("idle_wr_addr0", wr_addr0, 0);
            chk("idle_wr_din0", wr_din0, 0);
            chk("idle_wr_strb", wr_strb, 0);
        end
        if (ec) begin c_t.vld = 1'b0; last_core = 1'b1; end
        if (el) begin l_t.vld = 1'b0; last_core = 1'b0; end
        cg = c_gnt;
        lg = l_gnt;
        @(posedge clk);
        #1;
        k++;
    endtask

    // Asserts reset with whatever requests are being driven, checks outputs drop immediately, then releases
    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_c_gnt", c_gnt, 0);
        chk("rst_l_gnt", l_gnt, 0);
        chk("rst_c_rvalid", c_rvalid, 0);
        chk("rst_l_rvalid", l_rvalid, 0);
        chk("rst_we0", we0, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_rd_addr0", rd_addr0, 0);
        chk("rst_wr_addr0", wr_addr0, 0);
        chk("rst_wr_din0", wr_din0, 0);
        chk("rst_wr_strb", wr_strb, 0);
        c_t.vld = 1'b0;
        l_t.vld = 1'b0;
        drive();
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_c_rvalid", c_rvalid, 0);
            chk("rst_hold_we0", we0, 0);
        end
        @(posedge clk);
        #1;
        rst       = 1'b1;
        k         = 0;
        last_core = 1'b0;
        rv_c      = 1'b0;
        rv_l      = 1'b0;
        if (CLEAR) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        bit cg, lg;
        int gk;
        n_tests = 0;
        n_fail  = 0;
        k       = 0;
        c_t     = '0;
        l_t     = '0;
        rst     = 1'b0;
        preload = 1'b1;
        drive();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        preload = 1'b0;
        do_reset();

        // Core request held from reset release; granted only once the arbiter runs
        c_t = '{1'b1, 1'b0, 4'd0, 32'd0, SZ_WORD};
        gk  = -1;
        for (int i = 0; i < 40 && gk < 0; i++) begin
            cycle(cg, lg);
            if (cg) gk = k - 1;
        end
        chk("init_gnt_cycle", gk, INIT_CYC);
        cycle(cg, lg);

        // Loader readback of every word: zero after a sweep, preload pattern otherwise
        for (int a = 0; a < DEPTH; a++) begin
            l_t = '{1'b1, 1'b0, AW'(a), 32'd0, SZ_WORD};
            cycle(cg, lg);
            chk("ldr_rd_gnt", lg, 1);
        end
        cycle(cg, lg);

        c_t = '{1'b1, 1'b1, 4'd5, 32'h12345678, SZ_WORD};
        cycle(cg, lg);
        chk("core_wr_gnt", cg, 1);
        c_t = '{1'b1, 1'b0, 4'd5, 32'd0, SZ_WORD};
        cycle(cg, lg);
        chk("core_rd_gnt", cg, 1);
        cycle(cg, lg);

        // Contention: distinct data at 1 and 2, then both read continuously
        do_reset();
        repeat (INIT_CYC) cycle(cg, lg);
        c_t = '{1'b1, 1'b1, 4'd1, 32'h1111_0001, SZ_WORD};
        cycle(cg, lg);
        l_t = '{1'b1, 1'b1, 4'd2, 32'h2222_0002, SZ_WORD};
        cycle(cg, lg);
        for (int i = 0; i < 6; i++) begin
            if (!c_t.vld) c_t = '{1'b1, 1'b0, 4'd1, 32'd0, SZ_WORD};
            if (!l_t.vld) l_t = '{1'b1, 1'b0, 4'd2, 32'd0, SZ_WORD};
            cycle(cg, lg);
            chk("cont_c_gnt", cg, (i % 2) == 0);
            chk("cont_l_gnt", lg, (i % 2) == 1);
        end
        c_t.vld = 1'b0;
        l_t.vld = 1'b0;
        cycle(cg, lg);

        // Tie between loader write and core read of the same word
        do_reset();
        repeat (INIT_CYC) cycle(cg, lg);
        l_t = '{1'b1, 1'b1, 4'd3, 32'hA5A5A5A5, SZ_WORD};
        c_t = '{1'b1, 1'b0, 4'd3, 32'd0, SZ_WORD};
        cycle(cg, lg);
        chk("tie_core_first", cg, 1);
        chk("tie_ldr_waits", lg, 0);
        cycle(cg, lg);
        chk("tie_ldr_next", lg, 1);
        c_t = '{1'b1, 1'b0, 4'd3, 32'd0, SZ_WORD};
        cycle(cg, lg);
        chk("tie_reread_gnt", cg, 1);
        cycle(cg, lg);

        // Reset right after a granted core read, with fresh requests still asserted
        c_t = '{1'b1, 1'b0, 4'd7, 32'd0, SZ_WORD};
        cycle(cg, lg);
        chk("mid_rd_gnt", cg, 1);
        c_t = '{1'b1, 1'b0, 4'd4, 32'd0, SZ_WORD};
        l_t = '{1'b1, 1'b1, 4'd9, 32'h0BAD_F00D, SZ_WORD};
        drive();
        do_reset();

        for (int i = 0; i < 400; i++) begin
            if (!c_t.vld && $urandom_range(0, 2) != 0) c_t = rand_txn();
            if (!l_t.vld && $urandom_range(0, 2) != 0) l_t = rand_txn();
            cycle(cg, lg);
        end
        c_t.vld = 1'b0;
        l_t.vld = 1'b0;
        cycle(cg, lg);
        cycle(cg, lg);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Shares the single-port-pair `DataMem` (one read port, one write port, registered read) between two requesters:
  - the core load/store unit (`c_` port);
  - the test/loader port (`l_` port).
- Round-robin arbitration, at most one access per cycle.
- Optional zero-fill sweep of the whole memory after reset.
- Sits between the core/loader and `DataMem`; replaces hand-driven memory control in benches.

## Interface

Parameters
- `MEM_DEPTH`, default 16: words in `DataMem`.
- `ADDR_W`, default `$clog2(MEM_DEPTH)` = 4: word address width.
- `DATA_W`, default 32: data width.

Ports
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `c_req`  in  1  core request; held stable with all `c_` request fields until `c_gnt`.
- `c_we`  in  1  1 = write, 0 = read.
- `c_addr`  in  `ADDR_W`  word address.
- `c_wdata`  in  `DATA_W`  write data.
- `c_strb`  in  2  access size code, passed to `wr_strb`.
- `c_gnt`  out  1  request accepted this cycle.
- `c_rvalid`  out  1  read data valid on `c_rdata`.
- `c_rdata`  out  `DATA_W`  read data.
- `l_req`, `l_we`, `l_addr`, `l_wdata`, `l_strb`, `l_gnt`, `l_rvalid`, `l_rdata`: identical set for the loader.
- `rd_addr0`  out  `ADDR_W`  to `DataMem`.
- `wr_addr0`  out  `ADDR_W`  to `DataMem`.
- `wr_din0`  out  `DATA_W`  to `DataMem`.
- `we0`  out  1  to `DataMem`.
- `wr_strb`  out  2  to `DataMem`.
- `rd_dout0`  in  `DATA_W`  from `DataMem`; valid one cycle after `rd_addr0` is sampled.
- `init_done`  out  1  1 once the arbiter accepts requests.

## Operation

FSM states are `INIT` and `RUN`.
- Reset enters `INIT` when `DMEM_CLEAR_ON_RESET_EN` is defined, otherwise `RUN`.
- `INIT`:
  - sweeps `init_cnt` from 0 to `MEM_DEPTH-1`, driving `we0=1`, `wr_addr0=init_cnt`, `wr_din0=0`, `wr_strb=SZ_WORD`;
  - both grants are 0;
  - after the last address, moves to `RUN`.
- `RUN`:
  - If exactly one requester has `req` asserted, that requester is granted.
  - If both assert `req`, grant the one not granted last; `rr_last` resets to loader, so the core wins the first tie.
  - `rr_last` updates only on a grant.
- Granted write:
  - `we0=1`; `wr_addr0`, `wr_din0`, `wr_strb` come from the winner, combinationally in the grant cycle;
  - the write completes in that cycle and produces no response.
- Granted read:
  - `we0=0`; `rd_addr0` comes from the winner;
  - the owner bit and a pending flag are registered;
  - the next cycle, the owner's `rvalid` is 1.
- `c_rdata` and `l_rdata` are both wired to `rd_dout0`; they are meaningful only when the matching `rvalid` is 1.
- Idle cycles:
  - `we0=0`; write fields are 0;
  - `rd_addr0` holds its last value, which is harmless.
- Reads and writes never share a cycle. A read of an address written in the previous cycle returns the new data, because `DataMem` writes on the edge.

## Timing

- Reset values (`rst`=0):
  - `c_gnt`, `l_gnt`, `c_rvalid`, `l_rvalid`, `we0`, `init_done` = 0;
  - `rd_addr0`, `wr_addr0`, `wr_din0`, `wr_strb` = 0;
  - `init_cnt` = 0;
  - `rr_last` = loader.
- Grant is combinational, same cycle as `req`.
- Read latency: `rvalid` exactly 1 cycle after `gnt`.
- Write latency: 0; committed at the edge ending the grant cycle.
- Throughput: 1 access/cycle. With both requesters requesting continuously, grants strictly alternate.
- A requester may assert `req` again in the cycle its `rvalid` is high; back-to-back reads are pipelined.
- `init_done` rises in the first `RUN` cycle:
  - `MEM_DEPTH` cycles after reset release with the macro defined;
  - 1 cycle after release without it.
- Reset mid-operation: any pending `rvalid` is dropped and the FSM restarts in its reset state; requesters must reissue.
- `req` during `INIT`: ignored, no grant. The request stays pending until `RUN`.

## Configuration

- Macro `DMEM_CLEAR_ON_RESET_EN`.
- Defined: `INIT` sweep zero-fills all `MEM_DEPTH` words after every reset; `init_done` is delayed accordingly.
- Undefined:
  - no `INIT` state and no `init_cnt`;
  - memory contents persist across reset;
  - `init_done` = 1 from the first cycle after reset release.

## Structure

- Package `dmem_arb_pkg` holds:
  - size codes `SZ_BYTE`=2'b00, `SZ_HALF`=2'b01, `SZ_WORD`=2'b10;
  - FSM enum `dmem_arb_state_t` {`INIT`, `RUN`};
  - requester index constants `REQ_CORE`=0, `REQ_LDR`=1.
- Sub-module `dmem_rr_arb`: 2-way round-robin arbiter. It takes `req[1:0]` and an enable, outputs a one-hot `gnt[1:0]`, and owns `rr_last`.
- `dmem_arbiter` owns the FSM, `init_cnt`, read-return pipeline and memory mux.

## Test plan

- **Clear sweep:** macro defined; preload the memory with 32'hDEADBEEF everywhere, then release reset.
  - `init_done` must rise after 16 cycles.
  - Loader reads of addresses 0..15 must all return 0.
- **Single write then read:** core writes 32'h12345678 to address 5 (`SZ_WORD`), then reads address 5.
  - `c_gnt` must be high each cycle.
  - `c_rvalid` must be high 1 cycle after the read grant, with `c_rdata`=32'h12345678.
  - `l_rvalid` must stay 0.
- **Contention:** core reads address 1 and loader reads address 2, both continuously for 6 cycles.
  - Grant order must be C, L, C, L, C, L.
  - Each `rvalid` must go to the correct owner with the correct data.
- **Tie with write:** in the same cycle, loader writes 32'hA5A5A5A5 to address 3 and core reads address 3.
  - Core wins first (after reset), so its read returns the old value.
  - Loader is granted next.
  - A core re-read must return 32'hA5A5A5A5.
- **Reset mid-read:** grant a core read, then assert `rst` in the following cycle.
  - `c_rvalid` must stay 0.
  - All outputs must take their reset values immediately (asynchronously).
- **Request during `INIT`:** macro defined; core holds `req` from reset release.
  - No `c_gnt` during the 16 `INIT` cycles.
  - Grant in the first `RUN` cycle.
